// File: rtl/alu_pkg.sv
// Shared ALU/multiplier definitions: funct codes for MULT/MULTU and the
// multiply sequencer state encoding.
package alu_pkg;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mult_state_t;

  // True for the two funct codes the multiply sequencer accepts.
  function automatic logic is_mult_op(input logic [5:0] funct);
    return (funct == MULT) || (funct == MULTU);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration of the multiplier.
// Ports:
//   acc_in  - current 2*WIDTH accumulator
//   mcand   - multiplicand already shifted to the current digit position
//   mbits   - low BITS_PER_CYCLE multiplier bits for this iteration
//   acc_out - accumulator after adding this digit's partial product
module mult_step #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*WIDTH-1:0]        acc_in,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] mbits,
  output logic [2*WIDTH-1:0]        acc_out
);

  // Partial product built from shifted copies of the multiplicand.
  always_comb begin
    acc_out = acc_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mbits[i]) begin
        acc_out = acc_out + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Multi-cycle MULT/MULTU sequencer that owns the HI/LO registers.
// Ports:
//   clk, rst            - clock, async active-high reset
//   start, op_sel       - multiply request from EX and its funct code
//   rs_val, rt_val      - multiplicand / multiplier
//   mthi, mtlo, wr_data - HI/LO move writes
//   rd_req              - MFHI/MFLO present in EX
//   flush               - squash the in-flight multiply
//   hi_out, lo_out      - architectural HI/LO
//   busy                - multiply in progress
//   done                - one-cycle pulse after HI/LO take a product
//   stall               - combinational hazard stall request to the pipeline
module hilo_mult_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       op_sel,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = $clog2(N + 1);

  mult_state_t      state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             is_signed;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic             last_run;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    product;

  // A flush in the same IDLE cycle squashes the start.
  assign start_ok  = start & is_mult_op(op_sel) & ~flush;
  assign is_signed = (op_sel == MULT);

  // Magnitudes; negating the most-negative value wraps back onto itself,
  // which is exactly its unsigned magnitude.
  assign rs_mag = (is_signed & rs_val[WIDTH-1]) ? WIDTH'(~rs_val + WIDTH'(1)) : rs_val;
  assign rt_mag = (is_signed & rt_val[WIDTH-1]) ? WIDTH'(~rt_val + WIDTH'(1)) : rt_val;

  assign last_run = (cnt_q == CNT_W'(N - 1));
  assign product  = neg_q ? PW'(~acc_q + PW'(1)) : acc_q;

  mult_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc_in  (acc_q),
    .mcand   (mcand_q),
    .mbits   (mplier_q[BITS_PER_CYCLE-1:0]),
    .acc_out (acc_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = RUN;
      RUN: begin
        if (flush)         state_d = IDLE;
        else if (last_run) state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and HI/LO next values.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          mcand_d  = PW'(rs_mag);
          mplier_d = rt_mag;
          neg_d    = is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          // Moves are dropped when a multiply starts in the same cycle.
          if (mthi) hi_d = wr_data;
          if (mtlo) lo_d = wr_data;
        end
      end
      RUN: begin
        if (!flush) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << BITS_PER_CYCLE;
          mplier_d = mplier_q >> BITS_PER_CYCLE;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      FIX: begin
        if (!flush) begin
          hi_d   = product[PW-1:WIDTH];
          lo_d   = product[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and HI/LO registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);
  assign stall  = busy & (start | rd_req | mthi | mtlo);

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Scoreboard bench for hilo_mult_ctrl: products are predicted from plain
// 64-bit arithmetic and checked by a monitor whenever done pulses.
module tb_hilo_mult_ctrl;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, mthi, mtlo, rd_req, flush;
  logic [5:0]  op_sel;
  logic [31:0] rs_val, rt_val, wr_data;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, stall;

  logic        start2;
  logic [31:0] rs2, rt2;
  logic [31:0] hi2, lo2;
  logic        busy2, done2, stall2;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] e_mon;

  always #5 clk = ~clk;

  hilo_mult_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .wr_data(wr_data), .rd_req(rd_req), .flush(flush),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .stall(stall)
  );

  hilo_mult_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .op_sel(OP_MULTU),
    .rs_val(rs2), .rt_val(rt2), .mthi(1'b0), .mtlo(1'b0),
    .wr_data(32'h0), .rd_req(1'b0), .flush(1'b0),
    .hi_out(hi2), .lo_out(lo2), .busy(busy2), .done(done2), .stall(stall2)
  );

  // Reference product: full 64-bit signed or unsigned multiply.
  function automatic logic [63:0] ref_prod(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    if (op == OP_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'h0, a} * {32'h0, b};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding product.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: hi=%h lo=%h with nothing outstanding", hi_out, lo_out);
      end else begin
        e_mon = exp_q.pop_front();
        check("product", {hi_out, lo_out}, e_mon);
      end
    end
  end

  // Counts busy cycles until idle; ends one cycle past the done cycle.
  task automatic wait_idle(input string name, input int exp_busy);
    int  cnt = 0;
    bit  ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy still %0d after 200 cycles, required 0", name, busy);
    end
    check({name, "_busy_cycles"}, 64'(cnt), 64'(exp_busy));
    tick();
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    op_sel = op;
    rs_val = a;
    rt_val = b;
    start  = 1'b1;
    if (push) exp_q.push_back(ref_prod(op, a, b));
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [63:0] prod;
    logic [31:0] old_hi, old_lo;
    logic [5:0]  rop;
    int          bcnt;

    rst = 1'b1; start = 0; mthi = 0; mtlo = 0; rd_req = 0; flush = 0;
    op_sel = 6'h0; rs_val = 0; rt_val = 0; wr_data = 0;
    start2 = 0; rs2 = 0; rt2 = 0;
    repeat (2) tick();
    @(negedge clk);
    check("reset_state", {hi_out, lo_out, 29'h0, busy, done, stall}, 96'h0);
    tick();
    rst = 1'b0;
    tick();

    // Directed products.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_idle("multu_max", 33);
    check("multu_max_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_idle("mult_minneg", 33);
    check("mult_minneg_hilo", {hi_out, lo_out}, 64'h4000_0000_0000_0000);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_idle("mult_neg3x7", 33);
    check("mult_neg3x7_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Moves in IDLE.
    mthi = 1'b1; wr_data = 32'hAAAA_5555; tick();
    mthi = 1'b0; mtlo = 1'b1; wr_data = 32'h0F0F_0F0F; tick();
    mtlo = 1'b0;
    @(negedge clk);
    check("mthi_mtlo", {hi_out, lo_out}, 64'hAAAA_5555_0F0F_0F0F);
    tick();
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h5A5A_C3C3; tick();
    mthi = 1'b0; mtlo = 1'b0;
    @(negedge clk);
    check("mt_both", {hi_out, lo_out}, 64'h5A5A_C3C3_5A5A_C3C3);
    tick();

    // start and mthi together: only the product lands.
    mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
    issue(OP_MULTU, 32'd3, 32'd5, 1'b1);
    mthi = 1'b0;
    wait_idle("start_vs_mthi", 33);
    check("start_vs_mthi_hilo", {hi_out, lo_out}, 64'd15);

    // Invalid funct is ignored.
    issue(6'b011010, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    check("invalid_op_busy", 64'(busy), 64'd0);
    tick();

    // MFHI five cycles after start stalls until done, then sees the new HI.
    prod = ref_prod(OP_MULT, 32'hFFFE_1DC0, 32'd789);
    issue(OP_MULT, 32'hFFFE_1DC0, 32'd789, 1'b1);
    repeat (4) tick();
    rd_req = 1'b1;
    bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) begin
        check("mfhi_stall", 64'(stall), 64'd1);
      end else begin
        bcnt = 1;
        check("mfhi_done_nostall", {63'h0, stall}, 64'd0);
        check("mfhi_new_hi", 64'(hi_out), 64'(prod[63:32]));
        break;
      end
    end
    if (bcnt == 0) begin
      n_cmp++; n_err++;
      $display("FAIL mfhi_timeout: busy still 1, required 0");
    end
    tick();
    rd_req = 1'b0;

    // MTLO while busy: stalled, LO untouched until IDLE, then written.
    old_lo = lo_out;
    prod = ref_prod(OP_MULTU, 32'h0001_0003, 32'h0000_0100);
    issue(OP_MULTU, 32'h0001_0003, 32'h0000_0100, 1'b1);
    mtlo = 1'b1; wr_data = 32'h0000_1234;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      check("mtlo_busy_stall", 64'(stall), 64'd1);
      check("mtlo_busy_lo_hold", 64'(lo_out), 64'(old_lo));
    end
    check("mtlo_done_nostall", 64'(stall), 64'd0);
    tick();
    mtlo = 1'b0;
    @(negedge clk);
    check("mtlo_after_idle", {hi_out, lo_out}, {prod[63:32], 32'h0000_1234});
    tick();

    // Flush at RUN cycle 10: back to IDLE, HI/LO kept, no done.
    old_hi = hi_out; old_lo = lo_out;
    issue(OP_MULT, 32'd6, 32'd7, 1'b0);
    repeat (9) tick();
    flush = 1'b1; tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", 64'(busy), 64'd0);
    check("flush_hilo_kept", {hi_out, lo_out}, {old_hi, old_lo});
    repeat (40) tick();
    flush = 1'b1;
    issue(OP_MULTU, 32'd2, 32'd2, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_blocks_start", 64'(busy), 64'd0);
    tick();

    // Randomised products.
    for (int n = 0; n < 25; n++) begin
      rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_MULTU;
      issue(rop, pick_operand(), pick_operand(), 1'b1);
      wait_idle("random", 33);
    end

    // BITS_PER_CYCLE=4 instance.
    rs2 = 32'h1234_5678; rt2 = 32'h9ABC_DEF0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy2) bcnt++;
      else break;
    end
    check("bpc4_busy_cycles", 64'(bcnt), 64'd9);
    check("bpc4_done", {62'h0, done2, stall2}, 64'd2);
    check("bpc4_hilo", {hi2, lo2}, ref_prod(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
    check("bpc4_hilo_const", {hi2, lo2}, 64'h0B00_EA4E_242D_2080);
    tick();

    // Asynchronous reset in the middle of RUN.
    issue(OP_MULTU, 32'hFFFF_0000, 32'h0000_FFFF, 1'b0);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    check("async_reset", {hi_out, lo_out, 30'h0, busy, done}, 96'h0);
    tick();
    rst = 1'b0;
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
